// File: rtl/m72_irq_pkg.sv
// rtl/m72_irq_pkg.sv - shared constants and types for the M72 interrupt controller
package m72_irq_pkg;

  localparam logic [2:0] REG_LINE_LO = 3'd0;
  localparam logic [2:0] REG_LINE_HI = 3'd1;
  localparam logic [2:0] REG_CTRL    = 3'd2;
  localparam logic [2:0] REG_BASE    = 3'd3;
  localparam logic [2:0] REG_EOI     = 3'd4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_t;

  localparam logic [1:0] SRC_NONE = 2'b00;
  localparam logic [1:0] SRC_VBL  = 2'b01;
  localparam logic [1:0] SRC_RAS  = 2'b10;

  function automatic logic [7:0] irq_vector(input logic [4:0] base, input logic [2:0] ofs);
    return {base, 3'b000} + {5'b00000, ofs};
  endfunction

endpackage

// File: rtl/irq_edge_latch.sv
// rtl/irq_edge_latch.sv - rising-edge detector feeding one pending flag
module irq_edge_latch (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_level,
  input  logic i_en,
  input  logic i_clr,
  output logic o_pend
);

  logic r_level_q;
  logic r_pend;
  logic w_set;

  assign w_set = i_level & ~r_level_q & i_en;

  // A new edge outranks any clear arriving in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_level_q <= 1'b0;
      r_pend    <= 1'b0;
    end else begin
      r_level_q <= i_level;
      if (w_set)
        r_pend <= 1'b1;
      else if (i_clr || !i_en)
        r_pend <= 1'b0;
    end
  end

  assign o_pend = r_pend;

endmodule

// File: rtl/m72_irq_ctrl.sv
// rtl/m72_irq_ctrl.sv - vblank/raster interrupt controller with INTA/EOI handshake
module m72_irq_ctrl
  import m72_irq_pkg::*;
#(
  parameter logic [2:0] VBL_OFS    = 3'd0,
  parameter logic [2:0] RAS_OFS    = 3'd2,
  parameter logic [4:0] RESET_BASE = 5'h04
) (
  input  logic        CLK_32M,
  input  logic        RESET_N,
  input  logic        WR,
  input  logic [2:0]  ADDR,
  input  logic [15:0] DIN,
  input  logic        INTA,
  input  logic        VBLK,
  input  logic        HINT,
  output logic [1:0]  ISET,
  output logic [15:0] ISET_DATA,
  output logic        INTR,
  output logic [7:0]  VECTOR,
  output logic [7:0]  STATUS
);

  irq_state_t  r_state;
  logic [1:0]  r_ctrl;
  logic [4:0]  r_base;
  logic [1:0]  r_src;
  logic [7:0]  r_vector;
  logic [1:0]  r_iset;
  logic [15:0] r_iset_data;

  logic w_wr_lo;
  logic w_wr_hi;
  logic w_wr_ctrl;
  logic w_wr_base;
  logic w_eoi;
  logic w_vbl_pend;
  logic w_ras_pend;
  logic w_any_pend;
  logic w_ack;
  logic w_vbl_clr;
  logic w_ras_clr;
  logic w_ras_lvl;

  assign w_ras_lvl = HINT;

  assign w_wr_lo   = WR && (ADDR == REG_LINE_LO);
  assign w_wr_hi   = WR && (ADDR == REG_LINE_HI);
  assign w_wr_ctrl = WR && (ADDR == REG_CTRL);
  assign w_wr_base = WR && (ADDR == REG_BASE);
  assign w_eoi     = WR && (ADDR == REG_EOI);

  assign w_any_pend = w_vbl_pend | w_ras_pend;
  assign w_ack      = (r_state == REQ) && INTA && w_any_pend;

  // Vblank always wins, so the acknowledged source is raster only when vblank is idle.
  assign w_vbl_clr = (w_ack && w_vbl_pend)  || (w_wr_ctrl && !DIN[0]);
  assign w_ras_clr = (w_ack && !w_vbl_pend) || (w_wr_ctrl && !DIN[1]);

  irq_edge_latch u_vbl (
    .i_clk   (CLK_32M),
    .i_rst_n (RESET_N),
    .i_level (VBLK),
    .i_en    (r_ctrl[0]),
    .i_clr   (w_vbl_clr),
    .o_pend  (w_vbl_pend)
  );

  irq_edge_latch u_ras (
    .i_clk   (CLK_32M),
    .i_rst_n (RESET_N),
    .i_level (w_ras_lvl),
    .i_en    (r_ctrl[1]),
    .i_clr   (w_ras_clr),
    .o_pend  (w_ras_pend)
  );

  always_ff @(posedge CLK_32M or negedge RESET_N) begin
    if (!RESET_N) begin
      r_ctrl      <= 2'b00;
      r_base      <= RESET_BASE;
      r_iset      <= 2'b00;
      r_iset_data <= 16'h0000;
    end else begin
      if (w_wr_ctrl)
        r_ctrl <= DIN[1:0];
      if (w_wr_base)
        r_base <= DIN[7:3];
      r_iset      <= {w_wr_hi, w_wr_lo};
      r_iset_data <= (w_wr_lo || w_wr_hi) ? DIN : 16'h0000;
    end
  end

  always_ff @(posedge CLK_32M or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state  <= IDLE;
      r_src    <= SRC_NONE;
      r_vector <= 8'h00;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_pend)
            r_state <= REQ;
        end
        REQ: begin
          if (!w_any_pend) begin
            r_state <= IDLE;
          end else if (INTA) begin
            r_vector <= irq_vector(r_base, w_vbl_pend ? VBL_OFS : RAS_OFS);
            r_src    <= w_vbl_pend ? SRC_VBL : SRC_RAS;
            r_state  <= SERVICE;
          end
        end
        SERVICE: begin
          if (w_eoi) begin
            r_src   <= SRC_NONE;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign INTR      = (r_state == REQ);
  assign VECTOR    = r_vector;
  assign ISET      = r_iset;
  assign ISET_DATA = r_iset_data;
  assign STATUS    = {3'b000, r_src, w_ras_pend, w_vbl_pend, INTR};

endmodule

// File: tb/tb_m72_irq_ctrl.sv
// tb/tb_m72_irq_ctrl.sv - scoreboard bench for m72_irq_ctrl
module tb_m72_irq_ctrl;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr    = 1'b0;
  logic [2:0]  addr  = 3'd0;
  logic [15:0] din   = 16'h0000;
  logic        inta  = 1'b0;
  logic        vblk  = 1'b0;
  logic        hint  = 1'b0;
  logic        ras_lvl;
  logic [1:0]  iset;
  logic [15:0] iset_data;
  logic        intr;
  logic [7:0]  vector;
  logic [7:0]  status;

  assign ras_lvl = hint;

  always #5 clk = ~clk;

  m72_irq_ctrl dut (
    .CLK_32M   (clk),
    .RESET_N   (rst_n),
    .WR        (wr),
    .ADDR      (addr),
    .DIN       (din),
    .INTA      (inta),
    .VBLK      (vblk),
    .HINT      (ras_lvl),
    .ISET      (iset),
    .ISET_DATA (iset_data),
    .INTR      (intr),
    .VECTOR    (vector),
    .STATUS    (status)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending flags, enables, and a request/service phase.
  bit          m_en_v = 0, m_en_r = 0, m_pv = 0, m_pr = 0;
  bit          m_prev_v = 0, m_prev_h = 0, m_asking = 0, m_busy = 0;
  int          m_src = 0;
  logic [4:0]  m_base = 5'h04;
  logic [7:0]  m_vec = 8'h00;
  logic [1:0]  m_iset = 2'b00;
  logic [15:0] m_iset_data = 16'h0000;
  logic [17:0] q_iset[$];
  logic [7:0]  q_vec[$];

  always @(posedge clk or negedge rst_n) begin : model
    bit rv, rh, was_pv, was_pr, wrc, ack;
    if (!rst_n) begin
      m_en_v = 0; m_en_r = 0; m_pv = 0; m_pr = 0;
      m_prev_v = 0; m_prev_h = 0; m_asking = 0; m_busy = 0;
      m_src = 0; m_base = 5'h04; m_vec = 8'h00;
      m_iset = 2'b00; m_iset_data = 16'h0000;
      q_iset.delete();
      q_vec.delete();
    end else begin
      rv = vblk && !m_prev_v;
      rh = hint && !m_prev_h;
      m_prev_v = vblk;
      m_prev_h = hint;
      was_pv = m_pv;
      was_pr = m_pr;
      wrc = wr && (addr == 3'd2);
      ack = m_asking && inta && (was_pv || was_pr);
      if (rv && m_en_v) m_pv = 1;
      else if (!m_en_v || (ack && was_pv) || (wrc && !din[0])) m_pv = 0;
      if (rh && m_en_r) m_pr = 1;
      else if (!m_en_r || (ack && !was_pv) || (wrc && !din[1])) m_pr = 0;
      if (m_asking) begin
        if (!(was_pv || was_pr)) begin
          m_asking = 0;
        end else if (inta) begin
          m_vec = 8'(int'(m_base) * 8 + (was_pv ? 0 : 2));
          m_src = was_pv ? 1 : 2;
          m_asking = 0;
          m_busy = 1;
          q_vec.push_back(m_vec);
        end
      end else if (m_busy) begin
        if (wr && addr == 3'd4) begin
          m_busy = 0;
          m_src = 0;
        end
      end else if (was_pv || was_pr) begin
        m_asking = 1;
      end
      if (wrc) begin
        m_en_v = din[0];
        m_en_r = din[1];
      end
      if (wr && addr == 3'd3) m_base = din[7:3];
      m_iset = (wr && addr == 3'd0) ? 2'b01 : (wr && addr == 3'd1) ? 2'b10 : 2'b00;
      m_iset_data = (m_iset != 2'b00) ? din : 16'h0000;
      if (m_iset != 2'b00) q_iset.push_back({m_iset, m_iset_data});
    end
  end

  logic [1:0] prev_src = 2'b00;

  always @(negedge clk) begin
    logic [7:0] exp_status;
    if (!rst_n) begin
      prev_src = 2'b00;
    end else begin
      exp_status = {3'b000, 2'(m_src), m_pr, m_pv, m_asking};
      check("outputs", {intr, status, iset, iset_data, vector},
            {m_asking, exp_status, m_iset, m_iset_data, m_vec});
      if (iset != 2'b00) begin
        if (q_iset.size() == 0) check("iset_unexpected", {iset, iset_data}, 18'h0);
        else check("iset_event", {iset, iset_data}, q_iset.pop_front());
      end
      if (status[4:3] != 2'b00 && prev_src == 2'b00) begin
        if (q_vec.size() == 0) check("ack_unexpected", vector, 8'hxx);
        else check("ack_vector", vector, q_vec.pop_front());
      end
      prev_src = status[4:3];
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [15:0] d);
    wr = 1'b1; addr = a; din = d;
    tick();
    wr = 1'b0; addr = 3'd0; din = 16'h0000;
  endtask

  task automatic do_ack();
    inta = 1'b1;
    tick();
    inta = 1'b0;
  endtask

  initial begin
    tick(2);
    check("reset_outputs", {intr, status, iset, iset_data, vector}, 35'h0);
    rst_n = 1'b1;
    tick(2);

    wr_reg(3'd0, 16'h0080);
    check("iset_lo", {iset, iset_data}, {2'b01, 16'h0080});
    wr_reg(3'd1, 16'h0001);
    check("iset_hi", {iset, iset_data}, {2'b10, 16'h0001});
    tick();
    check("iset_idle", {iset, iset_data}, 18'h0);

    wr_reg(3'd2, 16'h0003);
    wr_reg(3'd3, 16'h0020);
    vblk = 1'b1;
    tick();
    check("vbl_pend_only", {intr, status}, {1'b0, 8'h02});
    tick();
    check("vbl_intr", intr, 1'b1);
    do_ack();
    check("vbl_vector", {intr, vector, status}, {1'b0, 8'h20, 8'h08});
    vblk = 1'b0;
    wr_reg(3'd4, 16'h0000);
    check("eoi_status", status, 8'h00);

    vblk = 1'b1; hint = 1'b1;
    tick(2);
    check("both_intr", intr, 1'b1);
    do_ack();
    check("both_first", {vector, status}, {8'h20, 8'h0C});
    vblk = 1'b0; hint = 1'b0;
    wr_reg(3'd4, 16'h0000);
    check("re_req_gap", intr, 1'b0);
    tick();
    check("re_req", intr, 1'b1);
    do_ack();
    check("both_second", {vector, status}, {8'h22, 8'h10});
    wr_reg(3'd4, 16'h0000);

    hint = 1'b1;
    tick(2);
    check("ras_req", {intr, status}, {1'b1, 8'h05});
    hint = 1'b0; vblk = 1'b1;
    tick();
    do_ack();
    check("preempt_vector", {vector, status}, {8'h20, 8'h0C});
    vblk = 1'b0;
    wr_reg(3'd4, 16'h0000);
    tick();
    do_ack();
    check("preempt_ras", vector, 8'h22);
    wr_reg(3'd4, 16'h0000);

    wr_reg(3'd2, 16'h0001);
    hint = 1'b1; tick(); hint = 1'b0;
    tick(3);
    check("ras_disabled", {intr, status[2]}, 2'b00);
    vblk = 1'b1;
    tick(2);
    check("vbl_req2", intr, 1'b1);
    vblk = 1'b0;
    wr_reg(3'd2, 16'h0000);
    tick();
    check("disable_drop", {intr, status, vector}, {1'b0, 8'h00, 8'h22});

    wr_reg(3'd2, 16'h0001);
    vblk = 1'b1;
    tick(2);
    do_ack();
    check("svc_before_reset", status, 8'h08);
    rst_n = 1'b0;
    #1;
    check("reset_mid", {intr, status, iset, iset_data, vector}, 35'h0);
    tick(2);
    rst_n = 1'b1;
    tick(3);
    wr_reg(3'd2, 16'h0001);
    tick(3);
    check("no_stale_edge", intr, 1'b0);
    vblk = 1'b0; tick();
    vblk = 1'b1; tick(2);
    check("retoggle_intr", intr, 1'b1);
    do_ack();
    check("retoggle_vec", vector, 8'h20);
    wr_reg(3'd4, 16'h0000);
    vblk = 1'b0;
    tick(2);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
      wr   = ($urandom_range(0, 5) == 0);
      addr = 3'($urandom_range(0, 7));
      din  = 16'($urandom);
      if (wr && addr == 3'd2 && $urandom_range(0, 3) != 0) din[1:0] = 2'b11;
      inta = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 5) == 0) vblk = ~vblk;
      if ($urandom_range(0, 4) == 0) hint = ~hint;
      tick();
    end
    wr = 1'b0; inta = 1'b0;
    tick(3);
    check("iset_queue_drained", q_iset.size(), 0);
    check("vec_queue_drained", q_vec.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
